scroll_ctrl: RTL
================

// Module: scroll_ctrl
// PURPOSE
//  Parametrised vertical-scroll and score controller for the crossy-road VGA game.
//  - Advances world y-offset by MOVE_AMT every `period` clocks while the player holds move_btn.
//  - Emits a one-cycle step pulse to follower obstacles.
//  - Keeps a saturating binary + BCD score, a run/pause/game-over state machine, and an optional difficulty ramp.
// PARAMETERS
//  YW          10      width of y_pos
//  SCREEN_H    480     wrap modulus for y_pos
//  Y_OFFSET    150     y_pos value after reset / restart
//  MOVE_AMT    2       pixels added per step (< SCREEN_H)
//  SPEED_INIT  100000  clocks between steps at level 0
//  SPEED_MIN   40000   floor on the step period
//  SPEED_STEP  10000   period reduction per level
//  SCORE_TICKS 70      steps per score point
//  SCORE_MAX   99      score saturation value (<= 99)
//  LEVEL_PTS   10      points per level increment
//  LEVEL_MAX   7       level saturation value (fits 3 bits)
// PORTS
//  clk        in   1    system clock (25 MHz pixel clock)
//  reset      in   1    synchronous, active-high reset
//  start      in   1    IDLE->RUN; OVER->IDLE (restart)
//  pause      in   1    level-sensitive pause request
//  collide    in   1    player hit; ends the game
//  move_btn   in   1    hold-to-scroll enable
//  y_pos      out  YW   current scroll offset, 0..SCREEN_H-1
//  step       out  1    one-cycle pulse on each scroll step (was move_followers)
//  score      out  7    binary score, 0..SCORE_MAX
//  score_bcd  out  8    {tens,units} BCD copy of score
//  level      out  3    difficulty level
//  state      out  2    00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
// BEHAVIOUR
//  - Reset: state=IDLE, y_pos=Y_OFFSET, step=0, score=0, score_bcd=0, level=0, ctr=0, score_ctr=0.
//  - All outputs are registered.
//  - FSM transitions:
//    - IDLE->RUN when start.
//    - RUN->PAUSE when pause.
//    - PAUSE->RUN when !pause.
//    - RUN or PAUSE -> OVER when collide. collide has priority over pause.
//    - OVER->IDLE when start; that transition reloads every reset value except state.
//  - ctr advances only in RUN with move_btn=1. Otherwise it holds, so resuming continues the same period.
//  - Period p = max(SPEED_MIN, SPEED_INIT - level*SPEED_STEP).
//  - When ctr >= p-1 in RUN with move_btn=1:
//    - ctr<=0 and step<=1 (next cycle).
//    - y_pos <= (y_pos+MOVE_AMT >= SCREEN_H) ? y_pos+MOVE_AMT-SCREEN_H : y_pos+MOVE_AMT. Modular wrap, not a reset to 0.
//  - step is 0 in every other cycle; consecutive steps are exactly p clocks apart.
//  - A collide in the same cycle as a step cancels that step: no y_pos, step or score change.
//  - On each step, score_ctr increments. When it is at SCORE_TICKS-1 it clears to 0 and score increments,
//    saturating at SCORE_MAX. score_bcd updates in the same cycle as score.
//  - Level increments in the same cycle as score whenever the new score is a nonzero multiple of LEVEL_PTS,
//    saturating at LEVEL_MAX. The new period takes effect from the next step.
//  - The sum y_pos+MOVE_AMT is computed YW+1 bits wide to avoid overflow.
//  - ctr is $clog2(SPEED_INIT+1) bits.
// CONFIGURATION
//  SCROLL_SPEEDUP_EN
//    - defined: difficulty ramp as above.
//    - undefined: level is tied to 0, p=SPEED_INIT always, and the ramp logic is not synthesised.
// STRUCTURE
//  - Package scroll_pkg holds:
//    - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_OVER;
//    - the BCD conversion function to_bcd(7b)->8b;
//    - default SCREEN_H / Y_OFFSET constants shared with the obstacle renderers.
//  - Sub-module scroll_tick_gen (ctr, period compare, step pulse; inputs en, period).
// TESTING
//  Bench params: SPEED_INIT=4, SPEED_MIN=2, SPEED_STEP=1, SCREEN_H=8, Y_OFFSET=6,
//  MOVE_AMT=3, SCORE_TICKS=2, LEVEL_PTS=2.
//  1. Reset, start, move_btn=1 -> step every 4 clocks; y_pos 6->1->4->7->2 (modular wrap).
//  2. move_btn pulsed low 2 clocks mid-period -> step delayed exactly 2 clocks; y_pos unchanged meanwhile.
//  3. 4 steps -> score=2, score_bcd=8'h02, level=1 (SPEEDUP_EN), then steps every 3 clocks;
//     with macro undefined, level=0 and steps stay every 4 clocks.
//  4. pause=1 and collide=1 in the same cycle during RUN -> state=OVER.
//     collide in a step cycle -> no step, y_pos held.
//  5. OVER, start=1 -> IDLE, y_pos=6, score=0, level=0.
//     reset asserted mid-period -> all reset values on the next clock.
//  6. Run until score saturates at SCORE_MAX=99 -> score_bcd=8'h99; further steps keep score at 99.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared scroll/score types: FSM encodings, BCD helper, default screen geometry.
// Pure declarations; no state, no flow control.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int SCREEN_H_DEF = 480;
  localparam int Y_OFFSET_DEF = 150;

  // Only valid for 0..99, which is all the score ever reaches.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(bin / 7'd10);
    units = 4'(bin % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Step timer: counts enabled clocks, fires when the count reaches period-1.
// fire_o is same-cycle combinational, step_o its registered copy; disabled clocks hold the count.
module scroll_tick_gen #(
  parameter int CW = 17
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [CW-1:0] period_i,
  output logic          fire_o,
  output logic          step_o
);

  logic [CW-1:0] ctr_q, ctr_d;
  logic          step_q, step_d;

  assign fire_o = en_i && (ctr_q >= (period_i - CW'(1)));

  always_comb begin
    ctr_d  = ctr_q;
    step_d = 1'b0;
    if (fire_o) begin
      ctr_d  = '0;
      step_d = 1'b1;
    end else if (en_i) begin
      ctr_d = ctr_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      ctr_q  <= '0;
      step_q <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/scroll_ctrl.sv
// Vertical scroll + score controller; all outputs registered, one-cycle step pulse per scroll.
// SCROLL_SPEEDUP_EN enables the level-driven period ramp; undefined ties level to 0.
module scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int YW          = 10,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int Y_OFFSET    = Y_OFFSET_DEF,
  parameter int MOVE_AMT    = 2,
  parameter int SPEED_INIT  = 100000,
  parameter int SPEED_MIN   = 40000,
  parameter int SPEED_STEP  = 10000,
  parameter int SCORE_TICKS = 70,
  parameter int SCORE_MAX   = 99,
  parameter int LEVEL_PTS   = 10,
  parameter int LEVEL_MAX   = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          collide,
  input  logic          move_btn,
  output logic [YW-1:0] y_pos,
  output logic          step,
  output logic [6:0]    score,
  output logic [7:0]    score_bcd,
  output logic [2:0]    level,
  output logic [1:0]    state
);

  localparam int CW  = $clog2(SPEED_INIT + 1);
  localparam int SCW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;

  state_t         state_q;
  logic [YW-1:0]  y_pos_q;
  logic [6:0]     score_q;
  logic [7:0]     score_bcd_q;
  logic [SCW-1:0] score_ctr_q;

  logic [CW-1:0]  period;
  logic           fire;
  logic           restart;
  logic [YW:0]    y_sum_d;
  logic [YW-1:0]  y_next_d;
  logic [6:0]     score_inc_d;

`ifdef SCROLL_SPEEDUP_EN
  logic [2:0] level_q;
  int         drop;

  assign drop   = int'(level_q) * SPEED_STEP;
  assign period = ((SPEED_INIT - drop) <= SPEED_MIN) ? CW'(SPEED_MIN) : CW'(SPEED_INIT - drop);
  assign level  = level_q;
`else
  assign period = CW'(SPEED_INIT);
  assign level  = 3'd0;
`endif

  assign restart     = (state_q == ST_OVER) && start;
  assign y_sum_d     = {1'b0, y_pos_q} + (YW+1)'(MOVE_AMT);
  assign y_next_d    = (y_sum_d >= (YW+1)'(SCREEN_H)) ? YW'(y_sum_d - (YW+1)'(SCREEN_H))
                                                      : y_sum_d[YW-1:0];
  assign score_inc_d = score_q + 7'd1;

  // A collide in a would-be step cycle suppresses the step and freezes the counter.
  scroll_tick_gen #(.CW(CW)) u_tick (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (restart),
    .en_i     ((state_q == ST_RUN) && move_btn && !collide),
    .period_i (period),
    .fire_o   (fire),
    .step_o   (step)
  );

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q     <= ST_IDLE;
      y_pos_q     <= YW'(Y_OFFSET);
      score_q     <= '0;
      score_bcd_q <= '0;
      score_ctr_q <= '0;
`ifdef SCROLL_SPEEDUP_EN
      level_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_q <= ST_RUN;
        ST_RUN:   if (collide) state_q <= ST_OVER;
                  else if (pause) state_q <= ST_PAUSE;
        ST_PAUSE: if (collide) state_q <= ST_OVER;
                  else if (!pause) state_q <= ST_RUN;
        ST_OVER:  ;
        default:  state_q <= ST_IDLE;
      endcase

      if (fire) begin
        y_pos_q <= y_next_d;
        if (score_ctr_q == SCW'(SCORE_TICKS - 1)) begin
          score_ctr_q <= '0;
          if (score_q < 7'(SCORE_MAX)) begin
            score_q     <= score_inc_d;
            score_bcd_q <= to_bcd(score_inc_d);
`ifdef SCROLL_SPEEDUP_EN
            if ((score_inc_d % 7'(LEVEL_PTS)) == 7'd0 && level_q < 3'(LEVEL_MAX))
              level_q <= level_q + 3'd1;
`endif
          end
        end else begin
          score_ctr_q <= score_ctr_q + SCW'(1);
        end
      end
    end
  end

  assign y_pos     = y_pos_q;
  assign score     = score_q;
  assign score_bcd = score_bcd_q;
  assign state     = state_q;

endmodule
